// File: rtl/averager_pkg.sv
// averager_pkg: shared types, widths and helpers for the averager accumulator
// acc_stage_t is sized by ACC_DATA_WIDTH/ACC_ADDR_WIDTH; the top's DATA_WIDTH/ADDR_WIDTH must match them.
package averager_pkg;
  localparam int ACC_DATA_WIDTH = 14;
  localparam int ACC_ADDR_WIDTH = 15;
  localparam int ACC_BRAM_LATENCY = 2;
  localparam int PIPE_DEPTH = ACC_BRAM_LATENCY + 2;
  localparam int WIDE = 64;
  typedef struct packed {
    logic valid;
    logic [ACC_ADDR_WIDTH-1:0] addr;
    logic signed [ACC_DATA_WIDTH-1:0] din;
    logic restart;
    logic wen;
  } acc_stage_t;
  function automatic logic signed [WIDE-1:0] sext_sample(input logic signed [ACC_DATA_WIDTH-1:0] d);
    return WIDE'(d);
  endfunction
  function automatic logic signed [WIDE-1:0] sat_sum(input logic signed [WIDE-1:0] s, input int w);
    logic signed [WIDE-1:0] mx, mn;
    mx = (WIDE'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    return s > mx ? mx : s < mn ? mn : s;
  endfunction
endpackage

// File: rtl/averager_delay_line.sv
// averager_delay_line: DEPTH-stage shift register of acc_stage_t
// Ports: clk, resetn (sync, active-low, clears valid bits), d in, q out (d delayed DEPTH cycles), busy (any stage valid).
module averager_delay_line
  import averager_pkg::*;
#(
  parameter int DEPTH = ACC_BRAM_LATENCY
) (
  input  logic       clk,
  input  logic       resetn,
  input  acc_stage_t d,
  output acc_stage_t q,
  output logic       busy
);
  acc_stage_t st [DEPTH];
  always_ff @(posedge clk) begin
    st[0] <= d;
    for (int i = 1; i < DEPTH; i++) st[i] <= st[i-1];
    if (!resetn) for (int i = 0; i < DEPTH; i++) st[i].valid <= 1'b0;
  end
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) busy = busy | st[i].valid;
  end
  assign q = st[DEPTH-1];
endmodule

// File: rtl/averager_accumulator.sv
// averager_accumulator: element-wise frame accumulation via BRAM read-modify-write, with result copy-out
// Ports: clk, resetn (sync, active-low); valid/din/addr_in/restart/wen_in sample stream;
//   rd_addr/rd_data accumulation BRAM read (BRAM_LATENCY cycles); acc_we/acc_addr/acc_data accumulation write;
//   out_we/out_addr/out_data result write; busy (samples in flight); overflow (sticky).
// Macro AVERAGER_ACC_SATURATE_EN: clamp overflowing sums instead of wrapping.
module averager_accumulator
  import averager_pkg::*;
#(
  parameter int DATA_WIDTH   = ACC_DATA_WIDTH,
  parameter int SUM_WIDTH    = 32,
  parameter int ADDR_WIDTH   = ACC_ADDR_WIDTH,
  parameter int BRAM_LATENCY = ACC_BRAM_LATENCY
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         valid,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [ADDR_WIDTH-1:0] addr_in,
  input  logic                         restart,
  input  logic                         wen_in,
  output logic        [ADDR_WIDTH-1:0] rd_addr,
  input  logic        [SUM_WIDTH-1:0]  rd_data,
  output logic                         acc_we,
  output logic        [ADDR_WIDTH-1:0] acc_addr,
  output logic        [SUM_WIDTH-1:0]  acc_data,
  output logic                         out_we,
  output logic        [ADDR_WIDTH-1:0] out_addr,
  output logic        [SUM_WIDTH-1:0]  out_data,
  output logic                         busy,
  output logic                         overflow
);
  acc_stage_t s0, sr;
  logic dl_busy, ovf;
  logic wh_we [BRAM_LATENCY];
  logic [ADDR_WIDTH-1:0] wh_addr [BRAM_LATENCY];
  logic [SUM_WIDTH-1:0] wh_data [BRAM_LATENCY];
  logic [SUM_WIDTH-1:0] fwd, sum;
  logic signed [SUM_WIDTH:0] sum_x;
  always_ff @(posedge clk)
    if (!resetn) s0 <= '0;
    else s0 <= '{valid, addr_in, din, restart, wen_in};
  assign rd_addr = s0.addr;
  averager_delay_line #(.DEPTH(BRAM_LATENCY)) u_delay (
    .clk(clk),
    .resetn(resetn),
    .d(s0),
    .q(sr),
    .busy(dl_busy)
  );
  // Writes from the current SW stage and the last BRAM_LATENCY cycles are not yet
  // visible in rd_data; scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd = rd_data;
    for (int i = BRAM_LATENCY - 1; i >= 0; i--)
      if (wh_we[i] && wh_addr[i] == sr.addr) fwd = wh_data[i];
    if (acc_we && acc_addr == sr.addr) fwd = acc_data;
  end
  assign sum_x = (sr.restart ? '0 : (SUM_WIDTH+1)'(signed'(fwd))) + (SUM_WIDTH+1)'(sext_sample(sr.din));
  assign ovf = sum_x[SUM_WIDTH] ^ sum_x[SUM_WIDTH-1];
`ifdef AVERAGER_ACC_SATURATE_EN
  assign sum = SUM_WIDTH'(sat_sum(WIDE'(sum_x), SUM_WIDTH));
`else
  assign sum = sum_x[SUM_WIDTH-1:0];
`endif
  always_ff @(posedge clk)
    if (!resetn) begin
      acc_we <= 1'b0;
      out_we <= 1'b0;
      acc_addr <= '0;
      acc_data <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < BRAM_LATENCY; i++) wh_we[i] <= 1'b0;
    end else begin
      acc_we <= sr.valid;
      out_we <= sr.valid & sr.wen;
      if (sr.valid) begin
        acc_addr <= sr.addr;
        acc_data <= sum;
      end
      overflow <= overflow | (sr.valid & ovf);
      wh_we[0] <= acc_we;
      for (int i = 1; i < BRAM_LATENCY; i++) wh_we[i] <= wh_we[i-1];
    end
  always_ff @(posedge clk) begin
    wh_addr[0] <= acc_addr;
    wh_data[0] <= acc_data;
    for (int i = 1; i < BRAM_LATENCY; i++) begin
      wh_addr[i] <= wh_addr[i-1];
      wh_data[i] <= wh_data[i-1];
    end
  end
  assign out_addr = acc_addr;
  assign out_data = acc_data;
  assign busy = s0.valid | dl_busy | acc_we;
endmodule

// File: tb/tb_averager_accumulator.sv
// tb_averager_accumulator: scoreboard bench with a BRAM model and a sequential sum model
module tb_averager_accumulator;
  import averager_pkg::*;
  localparam int DATA_W = 14;
  localparam int SUM_W = 16;
  localparam int ADDR_W = 15;
  typedef struct {
    int cyc;
    logic [ADDR_W-1:0] addr;
    logic [SUM_W-1:0] data;
    logic wen;
    logic ovf;
  } exp_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic valid = 1'b0;
  logic signed [DATA_W-1:0] din = '0;
  logic [ADDR_W-1:0] addr_in = '0;
  logic restart = 1'b0;
  logic wen_in = 1'b0;
  logic [ADDR_W-1:0] rd_addr, acc_addr, out_addr;
  logic [SUM_W-1:0] rd_data, acc_data, out_data;
  logic acc_we, out_we, busy, overflow;
  logic [SUM_W-1:0] mem [64];
  logic [SUM_W-1:0] p0, p1;
  logic [SUM_W-1:0] model [64];
  logic model_ovf = 1'b0;
  logic [ADDR_W-1:0] addr_smp = '0;
  logic rst_smp = 1'b0;
  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  averager_accumulator #(.SUM_WIDTH(SUM_W)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .din(din), .addr_in(addr_in),
    .restart(restart), .wen_in(wen_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .acc_we(acc_we), .acc_addr(acc_addr), .acc_data(acc_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  initial for (int i = 0; i < 64; i++) begin
    mem[i] = '0;
    model[i] = '0;
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    addr_smp <= addr_in;
    rst_smp <= resetn;
    if (acc_we) mem[acc_addr[7:2]] <= acc_data;
    p0 <= mem[rd_addr[7:2]];
    p1 <= p0;
  end
  assign rd_data = p1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic drive(input logic v, input int word, input int d, input logic rs, input logic w);
    longint s, mx, val;
    exp_t e;
    @(posedge clk);
    #1;
    valid = v;
    addr_in = ADDR_W'(word * 4);
    din = DATA_W'(d);
    restart = rs;
    wen_in = w;
    if (v) begin
      mx = (longint'(1) <<< (SUM_W - 1)) - 1;
      s = (rs ? 64'sd0 : longint'(signed'(model[word]))) + longint'(d);
      if (s > mx || s < -mx - 1) model_ovf = 1'b1;
`ifdef AVERAGER_ACC_SATURATE_EN
      val = s > mx ? mx : s < -mx - 1 ? -mx - 1 : s;
`else
      val = s;
`endif
      model[word] = SUM_W'(val);
      e.cyc = cyc;
      e.addr = ADDR_W'(word * 4);
      e.data = model[word];
      e.wen = w;
      e.ovf = model_ovf;
      q.push_back(e);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic reset_checks();
    @(negedge clk);
    check("rst_acc_we", acc_we, 0);
    check("rst_out_we", out_we, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_acc_addr", acc_addr, 0);
    check("rst_acc_data", acc_data, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_data", out_data, 0);
  endtask
  always @(negedge clk) if (resetn) begin
    exp_t e;
    check("busy", busy, q.size() > 0 && q[0].cyc < cyc);
    if (rst_smp) check("rd_addr", rd_addr, addr_smp);
    if (q.size() > 0 && q[0].cyc + PIPE_DEPTH <= cyc) begin
      e = q.pop_front();
      check("acc_we", acc_we, 1);
      check("acc_addr", acc_addr, e.addr);
      check("acc_data", acc_data, e.data);
      check("out_we", out_we, e.wen);
      check("overflow", overflow, e.ovf);
      if (e.wen) begin
        check("out_addr", out_addr, e.addr);
        check("out_data", out_data, e.data);
      end
    end else begin
      check("idle_acc_we", acc_we, 0);
      check("idle_out_we", out_we, 0);
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    reset_checks();
    for (int w = 0; w < 4; w++) drive(1'b1, w, w + 1, 1'b1, 1'b0);
    idle(6);
    for (int p = 0; p < 3; p++)
      for (int w = 0; w < 4; w++) drive(1'b1, w, -5, p == 0, 1'b0);
    for (int w = 0; w < 4; w++) drive(1'b1, w, 2, 1'b0, 1'b1);
    idle(6);
    for (int i = 0; i < 4; i++) drive(1'b1, 5, 7, i == 0, 1'b0);
    idle(6);
    drive(1'b1, 8, 1, 1'b1, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    drive(1'b1, 9, 2, 1'b1, 1'b0);
    drive(1'b1, 10, 3, 1'b1, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    idle(6);
    for (int i = 0; i < 6; i++) drive(1'b1, 11, 8191, i == 0, i == 5);
    idle(6);
    for (int w = 0; w < 3; w++) drive(1'b1, w, 3, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    valid = 1'b0;
    q.delete();
    model_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    reset_checks();
    idle(3);
    drive(1'b1, 3, -9, 1'b1, 1'b1);
    drive(1'b1, 3, 4, 1'b0, 1'b1);
    idle(3);
    for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
    check("drain", q.size(), 0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
